// File: rtl/f2c_dma_sched_pkg.sv
// Shared types and constants for the FPGA->CPU DMA scheduler.
package f2c_dma_sched_pkg;

    localparam int F2C_NUMCHUNKS_NBITS   = 3;
    localparam int F2C_CHUNKSIZE_NBITS   = 9;
    localparam int F2C_CHUNKSIZE         = 1 << F2C_CHUNKSIZE_NBITS;
    localparam int F2C_CHUNKSIZE_DWS     = F2C_CHUNKSIZE / 4;
    localparam int F2C_PAYLOAD_DWS_NBITS = 5;
    localparam int MTR_F2C_WRPTR         = 0;

    typedef logic [29:0] DWAddr;
    typedef logic [9:0]  DWCount;
    typedef logic [31:0] Data;
    typedef logic [F2C_NUMCHUNKS_NBITS-1:0] F2CChunkIndex;

    typedef enum logic {
        F2C_DATA   = 1'b0,
        F2C_METRIC = 1'b1
    } F2CReqKind;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_METRIC = 2'd2
    } f2c_state_e;

endpackage

// File: rtl/f2c_dma_sched_if.sv
// Request channel from the F2C scheduler to the TLP transmit engine.
interface f2c_dma_sched_if;
    import f2c_dma_sched_pkg::*;

    logic      txValid;
    logic      txReady;
    F2CReqKind txKind;
    DWAddr     txAddr;
    DWCount    txDwCount;
    Data       txData;

    modport master (
        output txValid, txKind, txAddr, txDwCount, txData,
        input  txReady
    );

    modport slave (
        input  txValid, txKind, txAddr, txDwCount, txData,
        output txReady
    );
endinterface

// File: rtl/f2c_dma_sched.sv
// F2C DMA scheduler: splits each ring chunk into max-payload write requests,
// then publishes the updated write pointer with a 1-DW metrics write.
module f2c_dma_sched
    import f2c_dma_sched_pkg::*;
#(
    parameter int CHUNK_NBITS       = F2C_NUMCHUNKS_NBITS,
    parameter int CHUNK_DWS_NBITS   = F2C_CHUNKSIZE_NBITS - 2,
    parameter int PAYLOAD_DWS_NBITS = F2C_PAYLOAD_DWS_NBITS
) (
    input  logic                   pcieClk_in,
    input  logic                   pcieRst_in,
    input  logic                   dmaEnable_in,
    input  DWAddr                  f2cBase_in,
    input  DWAddr                  mtrBase_in,
    input  logic [CHUNK_NBITS-1:0] f2cRdPtr_in,
    input  logic                   chunkAvail_in,
    output logic                   chunkDone_out,
    output logic [CHUNK_NBITS-1:0] f2cWrPtr_out,
    f2c_dma_sched_if.master        tx
);

    localparam int IDX_DIFF  = CHUNK_DWS_NBITS - PAYLOAD_DWS_NBITS;
    localparam int TLP_IDX_W = (IDX_DIFF > 0) ? IDX_DIFF : 1;
    localparam logic [TLP_IDX_W-1:0] LAST_IDX = TLP_IDX_W'((1 << IDX_DIFF) - 1);
    localparam DWCount PAYLOAD_DWS = DWCount'(1 << PAYLOAD_DWS_NBITS);

    f2c_state_e             state_q, state_d;
    logic [CHUNK_NBITS-1:0] wrPtr_q, wrPtr_d;
    logic [TLP_IDX_W-1:0]   tlpIdx_q, tlpIdx_d;
    logic                   valid_q, valid_d;
    F2CReqKind              kind_q, kind_d;
    DWAddr                  addr_q, addr_d;
    DWCount                 cnt_q, cnt_d;
    Data                    data_q, data_d;
    logic                   done_q, done_d;

    logic [CHUNK_NBITS-1:0] ptrInc;
    logic [TLP_IDX_W-1:0]   idxInc;
    logic                   full;
    logic                   xfer;

    function automatic DWAddr data_addr(input DWAddr base,
                                        input logic [CHUNK_NBITS-1:0] ptr,
                                        input logic [TLP_IDX_W-1:0] idx);
        return base + (DWAddr'(ptr) << CHUNK_DWS_NBITS)
                    + (DWAddr'(idx) << PAYLOAD_DWS_NBITS);
    endfunction

    assign ptrInc = wrPtr_q + CHUNK_NBITS'(1);
    assign idxInc = tlpIdx_q + TLP_IDX_W'(1);
    // One slot stays empty so wrPtr == rdPtr always means "ring empty".
    assign full   = (ptrInc == f2cRdPtr_in);
    assign xfer   = valid_q && tx.txReady;

    always_comb begin
        state_d  = state_q;
        wrPtr_d  = wrPtr_q;
        tlpIdx_d = tlpIdx_q;
        valid_d  = valid_q;
        kind_d   = kind_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!dmaEnable_in) begin
                    wrPtr_d = '0;
                end else if (chunkAvail_in && !full) begin
                    state_d  = ST_DATA;
                    tlpIdx_d = '0;
                    valid_d  = 1'b1;
                    kind_d   = F2C_DATA;
                    addr_d   = data_addr(f2cBase_in, wrPtr_q, '0);
                    cnt_d    = PAYLOAD_DWS;
                    data_d   = '0;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    if (tlpIdx_q == LAST_IDX) begin
                        // Chunk handed off: advance the pointer and publish it.
                        wrPtr_d = ptrInc;
                        done_d  = 1'b1;
                        state_d = ST_METRIC;
                        kind_d  = F2C_METRIC;
                        addr_d  = mtrBase_in + DWAddr'(MTR_F2C_WRPTR);
                        cnt_d   = DWCount'(1);
                        data_d  = Data'(ptrInc);
                    end else begin
                        tlpIdx_d = idxInc;
                        addr_d   = data_addr(f2cBase_in, wrPtr_q, idxInc);
                    end
                end
            end
            ST_METRIC: begin
                if (xfer) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pcieClk_in or posedge pcieRst_in) begin
        if (pcieRst_in) begin
            state_q  <= ST_IDLE;
            wrPtr_q  <= '0;
            tlpIdx_q <= '0;
            valid_q  <= 1'b0;
            kind_q   <= F2C_DATA;
            addr_q   <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wrPtr_q  <= wrPtr_d;
            tlpIdx_q <= tlpIdx_d;
            valid_q  <= valid_d;
            kind_q   <= kind_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign tx.txValid    = valid_q;
    assign tx.txKind     = kind_q;
    assign tx.txAddr     = addr_q;
    assign tx.txDwCount  = cnt_q;
    assign tx.txData     = data_q;
    assign chunkDone_out = done_q;
    assign f2cWrPtr_out  = wrPtr_q;

endmodule

// File: tb/tb_f2c_dma_sched.sv
// Directed bench for f2c_dma_sched: reset, chunk split, ring full/wrap,
// backpressure, enable drop mid-chunk and back-to-back chunks.
module tb_f2c_dma_sched;
    import f2c_dma_sched_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    DWAddr       f2cBase;
    DWAddr       mtrBase;
    logic [2:0]  rdPtr;
    logic        avail;
    logic        done;
    logic [2:0]  wrPtr;

    int n_assert = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;

    f2c_dma_sched_if tx();

    f2c_dma_sched dut (
        .pcieClk_in    (clk),
        .pcieRst_in    (rst),
        .dmaEnable_in  (en),
        .f2cBase_in    (f2cBase),
        .mtrBase_in    (mtrBase),
        .f2cRdPtr_in   (rdPtr),
        .chunkAvail_in (avail),
        .chunkDone_out (done),
        .f2cWrPtr_out  (wrPtr),
        .tx            (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && tx.txValid && tx.txReady) xfer_cnt <= xfer_cnt + 1;
        if (!rst && done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input logic [31:0] kind,
                              input logic [31:0] addr, input logic [31:0] cnt,
                              input logic [31:0] data);
        chk({tag, "_valid"}, 32'(tx.txValid), 1);
        chk({tag, "_kind"},  32'(tx.txKind), kind);
        chk({tag, "_addr"},  32'(tx.txAddr), addr);
        chk({tag, "_cnt"},   32'(tx.txDwCount), cnt);
        if (kind == 1) chk({tag, "_data"}, tx.txData, data);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic do_req(input string tag, input logic [31:0] kind,
                          input logic [31:0] addr, input logic [31:0] cnt,
                          input logic [31:0] data, input int stall);
        int w = 0;
        while (!tx.txValid && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!tx.txValid) begin
            chk({tag, "_timeout"}, 32'(tx.txValid), 1);
            return;
        end
        tx.txReady = (stall == 0);
        chk_fields(tag, kind, addr, cnt, data);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk_fields({tag, "_hold"}, kind, addr, cnt, data);
        end
        tx.txReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_chunk(input string tag, input logic [2:0] ptr, input int stall);
        logic [31:0] base;
        logic [2:0]  nxt;
        base = 32'h0004_0000 + 32'(ptr) * 32'h80;
        nxt  = ptr + 3'd1;
        for (int k = 0; k < 4; k++)
            do_req({tag, "_d"}, 0, base + 32'(k) * 32'h20, 32, 0, stall);
        do_req({tag, "_m"}, 1, 32'h0008_0000, 1, 32'(nxt), stall);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx.txValid) seen++;
        end
        chk(tag, 32'(seen), 0);
    endtask

    initial begin
        int x0, d0, w;
        rst = 1'b1; en = 1'b0; f2cBase = '0; mtrBase = '0;
        rdPtr = '0; avail = 1'b0; tx.txReady = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst_valid", 32'(tx.txValid), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_wrptr", 32'(wrPtr), 0);
        chk("rst_kind",  32'(tx.txKind), 0);
        chk("rst_addr",  32'(tx.txAddr), 0);
        chk("rst_cnt",   32'(tx.txDwCount), 0);
        chk("rst_data",  tx.txData, 0);

        // Basic chunk, then fill the ring until full.
        f2cBase = 30'h0004_0000; mtrBase = 30'h0008_0000;
        en = 1'b1; avail = 1'b1;
        rst = 1'b0;
        do_chunk("c0", 3'd0, 0);
        chk("c0_done", 32'(done_cnt), 1);
        chk("c0_wrptr", 32'(wrPtr), 1);
        for (int c = 1; c < 7; c++) do_chunk("fill", 3'(c), 0);
        expect_quiet("full_novalid", 10);
        chk("full_wrptr", 32'(wrPtr), 7);

        rdPtr = 3'd1;
        do_chunk("wrap", 3'd7, 0);
        chk("wrap_wrptr", 32'(wrPtr), 0);
        chk("wrap_done", 32'(done_cnt), 8);
        chk("wrap_xfers", 32'(xfer_cnt), 40);
        expect_quiet("wrap_full", 5);

        // Reset while a data request is pending.
        rdPtr = 3'd2;
        w = 0;
        while (!tx.txValid && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("midrst_pending", 32'(tx.txValid), 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(tx.txValid), 0);
        chk("midrst_addr",  32'(tx.txAddr), 0);
        chk("midrst_cnt",   32'(tx.txDwCount), 0);
        chk("midrst_kind",  32'(tx.txKind), 0);
        chk("midrst_data",  tx.txData, 0);
        chk("midrst_done",  32'(done), 0);
        chk("midrst_wrptr", 32'(wrPtr), 0);
        avail = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expect_quiet("postrst_idle", 3);
        chk("postrst_wrptr", 32'(wrPtr), 0);

        // Backpressure: five stalled cycles on every request.
        x0 = xfer_cnt; d0 = done_cnt;
        avail = 1'b1;
        do_req("bp_d", 0, 32'h0004_0000, 32, 0, 5);
        avail = 1'b0;
        do_req("bp_d", 0, 32'h0004_0020, 32, 0, 5);
        do_req("bp_d", 0, 32'h0004_0040, 32, 0, 5);
        do_req("bp_d", 0, 32'h0004_0060, 32, 0, 5);
        do_req("bp_m", 1, 32'h0008_0000, 1, 1, 5);
        chk("bp_xfers", 32'(xfer_cnt - x0), 5);
        chk("bp_done", 32'(done_cnt - d0), 1);
        chk("bp_wrptr", 32'(wrPtr), 1);

        // Enable dropped after the second data transfer.
        rdPtr = 3'd0; avail = 1'b1;
        do_req("en_d", 0, 32'h0004_0080, 32, 0, 0);
        do_req("en_d", 0, 32'h0004_00A0, 32, 0, 0);
        en = 1'b0;
        do_req("en_d", 0, 32'h0004_00C0, 32, 0, 0);
        do_req("en_d", 0, 32'h0004_00E0, 32, 0, 0);
        do_req("en_m", 1, 32'h0008_0000, 1, 2, 0);
        expect_quiet("en_novalid", 8);
        chk("en_wrptr", 32'(wrPtr), 0);

        // rdPtr advances as wrPtr increments; next chunk follows immediately.
        d0 = done_cnt;
        rdPtr = 3'd2; en = 1'b1;
        @(negedge clk);
        do_req("sim_d", 0, 32'h0004_0000, 32, 0, 0);
        do_req("sim_d", 0, 32'h0004_0020, 32, 0, 0);
        do_req("sim_d", 0, 32'h0004_0040, 32, 0, 0);
        rdPtr = 3'd3;
        do_req("sim_d", 0, 32'h0004_0060, 32, 0, 0);
        do_req("sim_m", 1, 32'h0008_0000, 1, 1, 0);
        chk("sim_gap", 32'(tx.txValid), 0);
        @(negedge clk);
        chk("sim_restart", 32'(tx.txValid), 1);
        do_chunk("sim2", 3'd1, 0);
        avail = 1'b0;
        chk("sim_done", 32'(done_cnt - d0), 2);
        chk("sim_wrptr", 32'(wrPtr), 2);
        expect_quiet("sim_full", 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/f2c_dma_sched.md
Name: f2c_dma_sched

Overview:
Scheduler for the FPGA->CPU DMA path. It tracks the F2C write pointer against the CPU-owned read pointer (F2C_RDPTR) and splits each 512-byte chunk into max-payload memory-write TLP requests to the TX engine. After each chunk it issues a 1-DW metrics write that publishes the new f2cWrPtr to the host metrics page. It sits between the F2C data source, the control registers (F2C_BASE, F2C_RDPTR, DMA_ENABLE, MTR_BASE) and the TLP transmit engine.

Parameters:
CHUNK_NBITS, F2C_NUMCHUNKS_NBITS (3), chunk-index width; ring holds 2**CHUNK_NBITS chunks.
CHUNK_DWS_NBITS, F2C_CHUNKSIZE_NBITS-2 (7), log2 of DWs per chunk (128).
PAYLOAD_DWS_NBITS, 5, log2 of DWs per data TLP (32 DW = 128 B); must be <= CHUNK_DWS_NBITS.

Ports:
pcieClk_in  in  1  PCIe core clock
pcieRst_in  in  1  asynchronous, active-high reset
dmaEnable_in  in  1  DMA_ENABLE register bit 0
f2cBase_in  in  30  DWAddr of host F2C ring; 4 KiB-aligned (bits 9:0 zero)
mtrBase_in  in  30  DWAddr of host metrics page; 4 KiB-aligned
f2cRdPtr_in  in  CHUNK_NBITS  CPU read pointer (next chunk CPU will consume)
chunkAvail_in  in  1  source holds a complete chunk
chunkDone_out  out  1  one-cycle pulse: chunk fully handed to TX, source may drop it
f2cWrPtr_out  out  CHUNK_NBITS  current write pointer
txValid_out  out  1  request valid
txReady_in  in  1  TX engine accepts request this cycle
txKind_out  out  1  F2C_DATA=0 (payload from source), F2C_METRIC=1 (payload = txData_out)
txAddr_out  out  30  DWAddr of write
txDwCount_out  out  10  DWCount of write
txData_out  out  32  metric payload (valid when txKind_out=F2C_METRIC)

Behaviour:
- Reset: state IDLE; wrPtr=0, tlpIdx=0; txValid_out=0, chunkDone_out=0, f2cWrPtr_out=0; txKind/txAddr/txDwCount/txData all 0.
- Handshake: transfer when txValid_out && txReady_in on a rising edge. Once txValid_out rises, it and all tx*_out fields hold stable until that transfer. No combinational path from txReady_in to txValid_out.
- full = (wrPtr+1 mod 2**CHUNK_NBITS) == f2cRdPtr_in. One slot is always kept empty.
- FSM:
  - IDLE: if !dmaEnable_in, clear wrPtr to 0. Else if chunkAvail_in && !full, go to DATA with tlpIdx=0. txValid_out rises the cycle after the condition is sampled true.
  - DATA: txKind=F2C_DATA; txAddr = f2cBase_in + (wrPtr<<CHUNK_DWS_NBITS) + (tlpIdx<<PAYLOAD_DWS_NBITS), mod 2**30; txDwCount = 2**PAYLOAD_DWS_NBITS. On transfer:
    - if tlpIdx is the last (2**(CHUNK_DWS_NBITS-PAYLOAD_DWS_NBITS)-1): wrPtr increments with wrap, chunkDone_out pulses next cycle, go to METRIC.
    - else tlpIdx increments.
  - METRIC: txKind=F2C_METRIC; txAddr=mtrBase_in (DW offset 0); txDwCount=1; txData = zero-extended updated wrPtr. On transfer, go to IDLE.
- Address fields are registered when each request is formed. Changes to f2cBase_in or mtrBase_in while a request is pending have no effect on it.
- dmaEnable_in deasserted mid-chunk: the current chunk and its metric write complete, then IDLE clears wrPtr. No partial chunk is ever abandoned.
- f2cRdPtr_in may change any cycle. It is only used for the full check in IDLE.
- chunkAvail_in is ignored outside IDLE.
- Async reset mid-operation: immediate return to reset values. A pending request is dropped, and the TX engine must discard it.

Decomposition:
- Add to tlp_xcvr_pkg:
  - enum F2CReqKind {F2C_DATA, F2C_METRIC}
  - F2C_PAYLOAD_DWS_NBITS = 5
  - F2C_CHUNKSIZE_DWS = F2C_CHUNKSIZE/4
  - MTR_F2C_WRPTR = 0 (metrics DW offset)
- Reuse the existing DWAddr, DWCount, Data and F2CChunkIndex types.
- Single module with no sub-module; the FSM plus two counters is below the threshold for splitting.

Test Plan:
1. Assert pcieRst_in mid-DATA with txValid_out=1 -> all outputs 0 in the same cycle; after release, wrPtr=0 and state is IDLE.
2. f2cBase_in=0x0004_0000, mtrBase_in=0x0008_0000, rdPtr=0, dmaEnable=1, chunkAvail=1, txReady=1 -> four requests at 0x40000, 0x40020, 0x40040, 0x40060, each dwCount 32; one chunkDone pulse; then metric at 0x80000 with data 1, dwCount 1.
3. Full/wrap: rdPtr=0, 7 chunks sent -> wrPtr=7, no txValid while rdPtr=0. Set rdPtr=1 -> chunk at 0x40380..0x403E0, wrPtr wraps to 0, metric data 0.
4. Backpressure: txReady low for 5 cycles on each request -> txValid, addr, count and kind stay stable; exactly one transfer per request; sequence as in scenario 2.
5. dmaEnable dropped after the 2nd data transfer -> remaining 2 data requests plus the metric still issued; then IDLE with f2cWrPtr_out=0; no new chunk despite chunkAvail=1.
6. Simultaneous events: rdPtr advances in the same cycle as wrPtr increments, and chunkAvail stays high -> next chunk starts one cycle after METRIC completes, with no lost or duplicated chunkDone.
